// File: rtl/arb_sched_if.sv
// Slave/formatter bus bundle for the packet arbiter.
// master: arbiter side; slave: slave FIFOs and formatter side.
interface arb_sched_if #(
  parameter int DW   = 32,
  parameter int CNTW = 6
);
  logic [DW-1:0]   slv0_data_i;
  logic [DW-1:0]   slv1_data_i;
  logic [DW-1:0]   slv2_data_i;
  logic            slv0_val_i;
  logic            slv1_val_i;
  logic            slv2_val_i;
  logic            slv0_req_i;
  logic            slv1_req_i;
  logic            slv2_req_i;
  logic [1:0]      slv0_prio_i;
  logic [1:0]      slv1_prio_i;
  logic [1:0]      slv2_prio_i;
  logic [1:0]      slv0_pkglen_i;
  logic [1:0]      slv1_pkglen_i;
  logic [1:0]      slv2_pkglen_i;
  logic            a2s0_ack_o;
  logic            a2s1_ack_o;
  logic            a2s2_ack_o;
  logic            f2a_id_req_i;
  logic            f2a_ack_i;
  logic            a2f_val_o;
  logic [DW-1:0]   a2f_data_o;
  logic [1:0]      a2f_id_o;
  logic [CNTW-1:0] a2f_pkglen_o;

  modport master (
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  slv0_val_i, slv1_val_i, slv2_val_i,
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    input  f2a_id_req_i, f2a_ack_i,
    output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    output a2f_val_o, a2f_data_o, a2f_id_o, a2f_pkglen_o
  );

  modport slave (
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output slv0_val_i, slv1_val_i, slv2_val_i,
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    output f2a_id_req_i, f2a_ack_i,
    input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
    input  a2f_val_o, a2f_data_o, a2f_id_o, a2f_pkglen_o
  );
endinterface

// File: rtl/arb_sched.sv
// 3-slave packet arbiter: priority + round-robin grant, word mux.
// Ports: clk_i, rstn_i (async low), bus (arb_sched_if.master).
module arb_sched #(
  parameter int DW   = 32,
  parameter int CNTW = 6
) (
  input logic        clk_i,
  input logic        rstn_i,
  arb_sched_if.master bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic [1:0]      gnt, gnt_nxt;
  logic [1:0]      last, last_nxt;
  logic [CNTW-1:0] len, len_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;

  logic [2:0]      req;
  logic [2:0]      ack;
  logic [1:0]      prio [3];
  logic [1:0]      best;
  logic [1:0]      start;
  logic [2:0]      idx;
  logic [1:0]      win;
  logic            hit;
  logic [1:0]      win_code;
  logic            sel_val;
  logic [DW-1:0]   sel_data;
  logic            a2f_val;
  logic [DW-1:0]   a2f_data;

  assign req = {bus.slv2_req_i, bus.slv1_req_i,
                bus.slv0_req_i};
  assign prio[0] = bus.slv0_prio_i;
  assign prio[1] = bus.slv1_prio_i;
  assign prio[2] = bus.slv2_prio_i;

  function automatic logic [CNTW-1:0] dec_len(
    input logic [1:0] code
  );
    return CNTW'(4) << code;
  endfunction

  // Lowest priority value wins; ties go to the first
  // requester found scanning up from last+1.
  always_comb begin
    best  = 2'd3;
    idx   = 3'd0;
    win   = 2'd0;
    hit   = 1'b0;
    for (int i = 0; i < 3; i++)
      if (req[i] && prio[i] <= best) best = prio[i];
    start = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, start} + 3'(k);
      if (idx > 3'd2) idx = idx - 3'd3;
      if (!hit && req[idx[1:0]] &&
          prio[idx[1:0]] == best) begin
        win = idx[1:0];
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    win_code = bus.slv0_pkglen_i;
    unique case (win)
      2'd1:    win_code = bus.slv1_pkglen_i;
      2'd2:    win_code = bus.slv2_pkglen_i;
      default: win_code = bus.slv0_pkglen_i;
    endcase
  end

  always_comb begin
    sel_val  = bus.slv0_val_i;
    sel_data = bus.slv0_data_i;
    unique case (gnt)
      2'd1: begin
        sel_val  = bus.slv1_val_i;
        sel_data = bus.slv1_data_i;
      end
      2'd2: begin
        sel_val  = bus.slv2_val_i;
        sel_data = bus.slv2_data_i;
      end
      default: begin
        sel_val  = bus.slv0_val_i;
        sel_data = bus.slv0_data_i;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    len_nxt   = len;
    cnt_nxt   = cnt;
    ack       = 3'b000;
    a2f_val   = 1'b0;
    a2f_data  = '0;
    unique case (state)
      IDLE: begin
        if (bus.f2a_id_req_i && |req) begin
          state_nxt = XFER;
          gnt_nxt   = win;
          len_nxt   = dec_len(win_code);
          cnt_nxt   = '0;
        end
      end
      XFER: begin
        a2f_val  = sel_val;
        a2f_data = sel_data;
        if (sel_val && bus.f2a_ack_i) begin
          ack     = 3'b001 << gnt;
          cnt_nxt = cnt + CNTW'(1);
          if (cnt == len - CNTW'(1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            last_nxt  = gnt;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      gnt   <= 2'd0;
      last  <= 2'd2;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.a2s0_ack_o   = ack[0];
  assign bus.a2s1_ack_o   = ack[1];
  assign bus.a2s2_ack_o   = ack[2];
  assign bus.a2f_val_o    = a2f_val;
  assign bus.a2f_data_o   = a2f_data;
  assign bus.a2f_id_o     = gnt;
  assign bus.a2f_pkglen_o = len;

endmodule
